// File: rtl/rsa_pkg.sv
// Shared constants for the Exp2 RSA block: state encoding, default widths,
// and multiplier operand-select codes.
package rsa_pkg;

  localparam int unsigned RSA_EXP_W = 256;
  localparam int unsigned RSA_CNT_W = 9;

  localparam logic MUL_OP_ST = 1'b0;
  localparam logic MUL_OP_TT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_CHK    = 3'd2,
    ST_MUL    = 3'd3,
    ST_WAIT_M = 3'd4,
    ST_SQ     = 3'd5,
    ST_WAIT_S = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/rsa_me_sched.sv
// LSB-first modular exponentiation sequencer: scans the exponent and orders
// S*T / T*T operations on a shared multiplier, gating the S/T registers.
module rsa_me_sched
  import rsa_pkg::*;
#(
  parameter int unsigned EXP_W = RSA_EXP_W,
  parameter int unsigned CNT_W = RSA_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [EXP_W-1:0] d_i,
  output logic             ready,
  output logic             done,
  output logic             s_init,
  output logic             mul_start,
  output logic             mul_sq,
  input  logic             mul_done,
  output logic             s_we,
  output logic             t_we,
  output logic [15:0]      mul_cnt
);

  state_e             state_q, state_d;
  logic [EXP_W-1:0]   d_sh_q, d_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        mul_cnt_q, mul_cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               s_init_q, s_init_d;
  logic               mul_start_q, mul_start_d;
  logic               mul_sq_q, mul_sq_d;

  // Next-state, scan bookkeeping, and registered strobes decoded from the next state.
  always_comb begin
    state_d     = state_q;
    d_sh_d      = d_sh_q;
    cnt_d       = cnt_q;
    mul_cnt_d   = mul_cnt_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    s_init_d    = 1'b0;
    mul_start_d = 1'b0;
    mul_sq_d    = MUL_OP_ST;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_sh_d    = d_i;
          cnt_d     = '0;
          mul_cnt_d = '0;
          state_d   = ST_INIT;
        end
      end
      ST_INIT: state_d = ST_CHK;
      ST_CHK: begin
        if ((d_sh_q == '0) || (cnt_q == CNT_W'(EXP_W))) begin
          state_d = ST_DONE;
        end else if (d_sh_q[0]) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_SQ;
        end
      end
      ST_MUL: state_d = ST_WAIT_M;
      ST_WAIT_M: begin
        // The squaring after the top set bit would never be used, so skip it.
        if (mul_done) begin
          state_d = (d_sh_q[EXP_W-1:1] == '0) ? ST_DONE : ST_SQ;
        end
      end
      ST_SQ: state_d = ST_WAIT_S;
      ST_WAIT_S: begin
        if (mul_done) begin
          d_sh_d  = d_sh_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_CHK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (((state_d == ST_MUL) || (state_d == ST_SQ)) && (mul_cnt_d != 16'hFFFF)) begin
      mul_cnt_d = mul_cnt_d + 16'd1;
    end

    ready_d     = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
    s_init_d    = (state_d == ST_INIT);
    mul_start_d = (state_d == ST_MUL) || (state_d == ST_SQ);
    mul_sq_d    = (state_d == ST_SQ) ? MUL_OP_TT : MUL_OP_ST;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      d_sh_q      <= '0;
      cnt_q       <= '0;
      mul_cnt_q   <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      s_init_q    <= 1'b0;
      mul_start_q <= 1'b0;
      mul_sq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_sh_q      <= d_sh_d;
      cnt_q       <= cnt_d;
      mul_cnt_q   <= mul_cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      s_init_q    <= s_init_d;
      mul_start_q <= mul_start_d;
      mul_sq_q    <= mul_sq_d;
    end
  end

  // Result write enables follow mul_done in the same cycle.
  assign s_we = (state_q == ST_WAIT_M) && mul_done;
  assign t_we = (state_q == ST_WAIT_S) && mul_done;

  assign ready     = ready_q;
  assign done      = done_q;
  assign s_init    = s_init_q;
  assign mul_start = mul_start_q;
  assign mul_sq    = mul_sq_q;
  assign mul_cnt   = mul_cnt_q;

endmodule

// File: tb/tb_rsa_me_sched.sv
// Bench for rsa_me_sched: multiplier model with programmable latency, job
// statistics monitor, and an operation-sequence reference derived from the exponent bits.
module tb_rsa_me_sched;

  localparam int unsigned EXP_W = 256;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [EXP_W-1:0] d_i;
  logic             ready, done, s_init, mul_start, mul_sq, mul_done, s_we, t_we;
  logic [15:0]      mul_cnt;

  rsa_me_sched #(.EXP_W(EXP_W), .CNT_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .d_i(d_i),
    .ready(ready), .done(done), .s_init(s_init), .mul_start(mul_start),
    .mul_sq(mul_sq), .mul_done(mul_done), .s_we(s_we), .t_we(t_we),
    .mul_cnt(mul_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model and job monitor share one process.
  int  l_cur = 1;
  bit  spur_chk = 1'b0;
  int  pend = 0;
  int  acc_cyc = 0, n_start = 0, n_swe = 0, n_twe = 0, n_init = 0, n_done = 0;
  int  done_cyc = 0, done_mcnt = 0, rdy_viol = 0;
  bit  in_job = 1'b0;
  bit  got_sq[$];

  initial begin
    mul_done = 1'b0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) mul_done = 1'b1;
      end
      if (mul_start === 1'b1) pend = l_cur;
      if (spur_chk && in_job && (cyc == acc_cyc + 2)) mul_done = 1'b1;
      #1;
      if (reset_n !== 1'b1) begin
        in_job = 1'b0;
      end else begin
        if (in_job && (ready !== 1'b0)) rdy_viol++;
        if (mul_start === 1'b1) begin n_start++; got_sq.push_back(mul_sq); end
        if (s_we === 1'b1) n_swe++;
        if (t_we === 1'b1) n_twe++;
        if (s_init === 1'b1) n_init++;
        if (done === 1'b1) begin
          n_done++; done_cyc = cyc; done_mcnt = int'(mul_cnt); in_job = 1'b0;
        end
        if ((start === 1'b1) && (ready === 1'b1)) begin
          acc_cyc = cyc; in_job = 1'b1;
          n_start = 0; n_swe = 0; n_twe = 0; n_init = 0; n_done = 0; rdy_viol = 0;
          got_sq.delete();
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
    chk("wait_ready", longint'(ok), 1);
  endtask

  task automatic run_job(input logic [EXP_W-1:0] d, input int lat_l, input bit noise,
                         input bit spur, input string tag);
    bit ok = 1'b0;
    wait_ready();
    l_cur = lat_l;
    spur_chk = spur;
    @(negedge clk); start = 1'b1; d_i = d;
    @(negedge clk); start = 1'b0; d_i = {8{$urandom}};
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (noise && (k >= 2) && (k <= 12)) begin start = 1'b1; d_i = {8{$urandom}}; end
      else start = 1'b0;
      #2;
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    spur_chk = 1'b0;
    chk($sformatf("%s.done_seen", tag), longint'(ok), 1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  // Reference: right-to-left scan, multiply on every set bit, square between bits.
  task automatic check_job(input logic [EXP_W-1:0] d, input int lat_l, input string tag);
    bit exp_q[$];
    int hb = -1;
    int n_mul = 0;
    int lat, mism;
    for (int i = 0; i < EXP_W; i++) if (d[i]) hb = i;
    for (int i = 0; i <= hb; i++) begin
      if (d[i]) begin exp_q.push_back(1'b0); n_mul++; end
      if (i < hb) exp_q.push_back(1'b1);
    end
    lat = (hb < 0) ? 3 : 2 + (hb + 1) + exp_q.size() * (1 + lat_l);
    mism = (got_sq.size() != exp_q.size()) ? 1 : 0;
    if (mism == 0) foreach (exp_q[i]) if (got_sq[i] != exp_q[i]) mism++;
    chk($sformatf("%s.mul_cnt", tag), done_mcnt, exp_q.size());
    chk($sformatf("%s.n_start", tag), n_start, exp_q.size());
    chk($sformatf("%s.s_we", tag), n_swe, n_mul);
    chk($sformatf("%s.t_we", tag), n_twe, exp_q.size() - n_mul);
    chk($sformatf("%s.s_init", tag), n_init, 1);
    chk($sformatf("%s.n_done", tag), n_done, 1);
    chk($sformatf("%s.latency", tag), done_cyc - acc_cyc, lat);
    chk($sformatf("%s.ready_low", tag), rdy_viol, 0);
    chk($sformatf("%s.ready_back", tag), longint'(ready), 1);
    chk($sformatf("%s.sq_seq_mism", tag), mism, 0);
  endtask

  typedef struct {
    logic [EXP_W-1:0] d;
    int               lat_l;
    int               exp_cnt;
    int               exp_lat;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [EXP_W-1:0] r;
    logic [EXP_W-1:0] top;
    int lr;

    top = '0; top[EXP_W-1] = 1'b1;
    tbl[0] = '{d: '0,                  lat_l: 1, exp_cnt: 0,   exp_lat: 3};
    tbl[1] = '{d: EXP_W'(1),           lat_l: 4, exp_cnt: 1,   exp_lat: 8};
    tbl[2] = '{d: EXP_W'(5),           lat_l: 2, exp_cnt: 4,   exp_lat: 17};
    tbl[3] = '{d: EXP_W'(2),           lat_l: 3, exp_cnt: 2,   exp_lat: 12};
    tbl[4] = '{d: '1,                  lat_l: 1, exp_cnt: 511, exp_lat: 1280};
    tbl[5] = '{d: top,                 lat_l: 1, exp_cnt: 256, exp_lat: 770};

    reset_n = 1'b0; start = 1'b0; d_i = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst.ready", longint'(ready), 1);
    chk("rst.strobes", longint'({done, s_init, mul_start, mul_sq, s_we, t_we}), 0);
    chk("rst.mul_cnt", longint'(mul_cnt), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_job(tbl[v].d, tbl[v].lat_l, 1'b0, 1'b0, tag);
      check_job(tbl[v].d, tbl[v].lat_l, tag);
      chk($sformatf("%s.tbl_cnt", tag), done_mcnt, tbl[v].exp_cnt);
      chk($sformatf("%s.tbl_lat", tag), done_cyc - acc_cyc, tbl[v].exp_lat);
    end

    // start noise through WAIT_S plus a stray mul_done in the first CHK.
    run_job(EXP_W'(5), 3, 1'b1, 1'b1, "noise5");
    check_job(EXP_W'(5), 3, "noise5");
    chk("noise5.lat_const", done_cyc - acc_cyc, 21);

    // Reset while waiting on the first multiply of d=5.
    wait_ready();
    l_cur = 6;
    @(negedge clk); start = 1'b1; d_i = EXP_W'(5);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("midrst.ready", longint'(ready), 1);
    chk("midrst.strobes", longint'({done, s_init, mul_start, mul_sq, s_we, t_we}), 0);
    chk("midrst.mul_cnt", longint'(mul_cnt), 0);
    repeat (6) @(negedge clk);
    #2;
    chk("midrst.late_done_swe", n_swe, 0);
    chk("midrst.late_done_twe", n_twe, 0);
    chk("midrst.n_done", n_done, 0);
    run_job(EXP_W'(1), 4, 1'b0, 1'b0, "postrst");
    check_job(EXP_W'(1), 4, "postrst");

    for (int j = 0; j < 8; j++) begin
      string tag;
      tag = $sformatf("rnd%0d", j);
      r = {8{$urandom}};
      r = r >> $urandom_range(0, EXP_W - 1);
      if ($urandom_range(0, 1) == 1) r = r & {8{$urandom}};
      lr = $urandom_range(1, 4);
      run_job(r, lr, 1'b0, 1'b0, tag);
      check_job(r, lr, tag);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
